clk_div_multi: RTL and testbench

//  Multi-channel programmable clock divider/pulse generator. Derives NUM_CH independent slow

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_multi_if.sv | 24 ++
 rtl/clk_div_chan.sv | 90 +++++++++
 rtl/clk_div_multi.sv | 53 +++++
 tb/tb_clk_div_multi.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
    localparam int DIV_MIN       = 2;
    localparam int DEFAULT_DIV_C = 12000000;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle between the control logic and the divider block.
interface clk_div_multi_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 25,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] en_in;
    logic              sync_in;
    logic              div_we_in;
    logic [CH_W-1:0]   div_ch_in;
    logic [CNT_W-1:0]  div_val_in;
    logic              div_err_out;
    logic [NUM_CH-1:0] clk_div_pulse_out;
    logic [NUM_CH-1:0] clk_div_sq_out;

    modport master (
        output en_in, sync_in, div_we_in, div_ch_in, div_val_in,
        input  div_err_out, clk_div_pulse_out, clk_div_sq_out
    );
    modport slave (
        input  en_in, sync_in, div_we_in, div_ch_in, div_val_in,
        output div_err_out, clk_div_pulse_out, clk_div_sq_out
    );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow divisor, registered pulse and square wave.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             sync_in,
    input  logic             wr_in,
    input  logic [CNT_W-1:0] val_in,
    output logic             pulse_out,
    output logic             sq_out
);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] a_q, a_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             pulse_q, pulse_d;
    logic             sq_q, sq_d;
    logic             last;
    logic [CNT_W-1:0] a_next;

    always_comb begin
        cnt_d     = cnt_q;
        a_d       = a_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pulse_d   = 1'b0;
        sq_d      = 1'b0;
        last      = (cnt_q == a_q - ONE);
        a_next    = pending_q ? shadow_q : a_q;

        if (!en_in) begin
            // Park on the last count so re-enable pulses on the very next cycle.
            a_d       = a_next;
            pending_d = 1'b0;
            cnt_d     = a_next - ONE;
        end else if (sync_in) begin
            // Forced period boundary: pulse now, restart the count from zero.
            a_d       = a_next;
            pending_d = 1'b0;
            cnt_d     = '0;
            pulse_d   = 1'b1;
            sq_d      = 1'b1;
        end else begin
            pulse_d = last;
            sq_d    = last || (cnt_q < (a_q >> 1) - ONE);
            if (last) begin
                cnt_d     = '0;
                a_d       = a_next;
                pending_d = 1'b0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        // A write landing on a boundary stays pending for the following one.
        if (wr_in) begin
            shadow_d  = val_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q     <= DEF - ONE;
            a_q       <= DEF;
            shadow_q  <= DEF;
            pending_q <= 1'b0;
            pulse_q   <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            sq_q      <= sq_d;
        end
    end

    assign pulse_out = pulse_q;
    assign sq_out    = sq_q;
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: write decode/validation plus an array of channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
    input logic           clk_in,
    input logic           rst_n_in,
    clk_div_multi_if.slave bus
);
    localparam int CH_W = ch_w(NUM_CH);

    logic              ch_ok;
    logic              val_ok;
    logic              wr_ok;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] sq;

    always_comb begin
        ch_ok  = (int'(bus.div_ch_in) < NUM_CH);
        val_ok = (bus.div_val_in >= CNT_W'(DIV_MIN));
        wr_ok  = bus.div_we_in && ch_ok && val_ok;
        err_d  = bus.div_we_in && !(ch_ok && val_ok);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .en_in     (bus.en_in[i]),
            .sync_in   (bus.sync_in),
            .wr_in     (wr_ok && (bus.div_ch_in == CH_W'(i))),
            .val_in    (bus.div_val_in),
            .pulse_out (pulse[i]),
            .sq_out    (sq[i])
        );
    end

    assign bus.div_err_out       = err_q;
    assign bus.clk_div_pulse_out = pulse;
    assign bus.clk_div_sq_out    = sq;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with 3 channels, 8-bit counters, default divisor 6.
module tb_clk_div_multi;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic [31:0] pm, sm, pm1, sm1, em;

    always #5 clk_in = ~clk_in;

    clk_div_multi_if #(.NUM_CH(3), .CNT_W(8), .CH_W(2)) bus ();

    clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(6)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input logic [31:0] p, input logic [31:0] s);
        chk({tag, "_pulse"}, 32'(bus.clk_div_pulse_out[ch]), 32'(p[cyc]));
        chk({tag, "_sq"},    32'(bus.clk_div_sq_out[ch]),    32'(s[cyc]));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.en_in      = '0;
        bus.sync_in    = 1'b0;
        bus.div_we_in  = 1'b0;
        bus.div_ch_in  = '0;
        bus.div_val_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_in = 1'b0;
        #3;
        chk("rst_pulse", 32'(bus.clk_div_pulse_out), 32'd0);
        chk("rst_sq",    32'(bus.clk_div_sq_out),    32'd0);
        chk("rst_err",   32'(bus.div_err_out),       32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        cyc = 0;
    endtask

    initial begin
        idle_inputs();

        // 1: default divisor 6 on ch0, others idle
        do_reset();
        pm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 13);
        sm = 32'h0000_E38E;                      // cycles 1-3, 7-9, 13-15
        bus.en_in = 3'b001;
        for (int i = 0; i < 14; i++) begin
            step();
            chk_ch("s1_ch0", 0, pm, sm);
            chk("s1_others", 32'({bus.clk_div_pulse_out[2:1], bus.clk_div_sq_out[2:1]}), 32'd0);
        end

        // 2: write 5 mid-period; current period finishes at 6 cycles
        do_reset();
        pm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 12) | (32'd1 << 17);
        sm = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 8)
           | (32'd1 << 12) | (32'd1 << 13) | (32'd1 << 17) | (32'd1 << 18);
        bus.en_in = 3'b001;
        for (int i = 0; i < 18; i++) begin
            bus.div_we_in  = (cyc == 3);
            bus.div_ch_in  = 2'd0;
            bus.div_val_in = 8'd5;
            step();
            chk_ch("s2_ch0", 0, pm, sm);
        end
        bus.div_we_in = 1'b0;

        // 3: rejected writes (val=1, ch=3) flag one cycle each, period unchanged
        do_reset();
        pm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 13);
        sm = 32'h0000_E38E;
        em = (32'd1 << 3) | (32'd1 << 5);
        bus.en_in = 3'b001;
        for (int i = 0; i < 14; i++) begin
            bus.div_we_in  = (cyc == 2) || (cyc == 4);
            bus.div_ch_in  = (cyc == 4) ? 2'd3 : 2'd0;
            bus.div_val_in = (cyc == 2) ? 8'd1 : 8'd5;
            step();
            chk_ch("s3_ch0", 0, pm, sm);
            chk("s3_err", 32'(bus.div_err_out), 32'(em[cyc]));
        end
        bus.div_we_in = 1'b0;

        // 4: disable at 9, re-enable at 20
        do_reset();
        pm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 21) | (32'd1 << 27);
        sm = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 8)
           | (32'd1 << 9) | (32'd1 << 21) | (32'd1 << 22) | (32'd1 << 23) | (32'd1 << 27)
           | (32'd1 << 28);
        for (int i = 0; i < 28; i++) begin
            bus.en_in = (cyc >= 9 && cyc < 20) ? 3'b000 : 3'b001;
            step();
            chk_ch("s4_ch0", 0, pm, sm);
        end

        // 5: ch1 set to 4, sync at 9 aligns ch0 (A=6) and ch1 (A=4)
        do_reset();
        pm  = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 10) | (32'd1 << 16) | (32'd1 << 22);
        sm  = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 8)
            | (32'd1 << 9) | (32'd1 << 10) | (32'd1 << 11) | (32'd1 << 12) | (32'd1 << 16)
            | (32'd1 << 17) | (32'd1 << 18) | (32'd1 << 22) | (32'd1 << 23);
        pm1 = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 10) | (32'd1 << 14) | (32'd1 << 18)
            | (32'd1 << 22);
        sm1 = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 8)
            | (32'd1 << 10) | (32'd1 << 11) | (32'd1 << 14) | (32'd1 << 15) | (32'd1 << 18)
            | (32'd1 << 19) | (32'd1 << 22) | (32'd1 << 23);
        bus.en_in = 3'b011;
        for (int i = 0; i < 23; i++) begin
            bus.div_we_in  = (cyc == 0);
            bus.div_ch_in  = 2'd1;
            bus.div_val_in = 8'd4;
            bus.sync_in    = (cyc == 9);
            step();
            chk_ch("s5_ch0", 0, pm, sm);
            chk_ch("s5_ch1", 1, pm1, sm1);
            chk("s5_ch2", 32'({bus.clk_div_pulse_out[2], bus.clk_div_sq_out[2]}), 32'd0);
        end
        bus.sync_in   = 1'b0;
        bus.div_we_in = 1'b0;

        // 6: pending write then async reset mid-period; reset divisor returns, pending dropped
        do_reset();
        bus.en_in = 3'b001;
        for (int i = 0; i < 3; i++) begin
            bus.div_we_in  = (cyc == 2);
            bus.div_ch_in  = 2'd0;
            bus.div_val_in = 8'd3;
            step();
        end
        bus.div_we_in = 1'b0;
        chk("s6_sq_before", 32'(bus.clk_div_sq_out[0]), 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("s6_async_pulse", 32'(bus.clk_div_pulse_out), 32'd0);
        chk("s6_async_sq",    32'(bus.clk_div_sq_out),    32'd0);
        do_reset();
        pm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 13);
        sm = 32'h0000_E38E;
        bus.en_in = 3'b001;
        for (int i = 0; i < 14; i++) begin
            step();
            chk_ch("s6_ch0", 0, pm, sm);
        end

        // 7: write 4 on the boundary with 5 pending -> periods 5 then 4
        do_reset();
        pm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 12) | (32'd1 << 16) | (32'd1 << 20);
        sm = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 8)
           | (32'd1 << 12) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 17) | (32'd1 << 20)
           | (32'd1 << 21);
        bus.en_in = 3'b001;
        for (int i = 0; i < 21; i++) begin
            bus.div_we_in  = (cyc == 2) || (cyc == 6);
            bus.div_ch_in  = 2'd0;
            bus.div_val_in = (cyc == 2) ? 8'd5 : 8'd4;
            step();
            chk_ch("s7_ch0", 0, pm, sm);
        end
        bus.div_we_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
